// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode field, HALT encoding and fetch-stage enums.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned OPCODE_LSB = WORD_W - OPCODE_W;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t HALT = 6'b111111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Action applied by the fetch stage in a given cycle, in priority order.
    typedef enum logic [2:0] {
        ACT_STALL    = 3'd0,
        ACT_REDIRECT = 3'd1,
        ACT_FREEZE   = 3'd2,
        ACT_FETCH    = 3'd3,
        ACT_BUBBLE   = 3'd4
    } fetch_act_t;

    function automatic opcode_t opcode_of(input word_t instr);
        return opcode_t'(instr[WORD_W-1:OPCODE_LSB]);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle for the fetch stage; modport fs is the stage's view.
// Counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  freeze;
    logic  flush;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  mem_stall;
    logic  imemREN;
    word_t imemaddr;
    word_t ifid_instr;
    word_t ifid_pc4;
    logic  ifid_valid;
`ifdef FETCH_PERF_EN
    word_t freeze_cnt;
    word_t flush_cnt;
    word_t miss_cnt;
`endif

    modport fs (
        input  ihit, imemload, freeze, flush, redirect_valid, redirect_pc, mem_stall,
        output imemREN, imemaddr, ifid_instr, ifid_pc4, ifid_valid
`ifdef FETCH_PERF_EN
        , output freeze_cnt, flush_cnt, miss_cnt
`endif
    );

endinterface

// File: rtl/fetch_perf_counters.sv
// Wrapping event counters for freeze, flush and fetch-miss cycles.
module fetch_perf_counters
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  freeze_ev,
    input  logic  flush_ev,
    input  logic  miss_ev,
    output word_t freeze_cnt,
    output word_t flush_cnt,
    output word_t miss_cnt
);

    word_t freeze_cnt_q, freeze_cnt_d;
    word_t flush_cnt_q,  flush_cnt_d;
    word_t miss_cnt_q,   miss_cnt_d;

    always_comb begin
        freeze_cnt_d = freeze_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (freeze_ev) freeze_cnt_d = freeze_cnt_q + WORD_W'(1);
        if (flush_ev)  flush_cnt_d  = flush_cnt_q  + WORD_W'(1);
        if (miss_ev)   miss_cnt_d   = miss_cnt_q   + WORD_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
            miss_cnt_q   <= '0;
        end else begin
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign freeze_cnt = freeze_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch and RUN/HALTED control.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        freeze,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        mem_stall,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] freeze_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] miss_cnt
`endif
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        instr_q, instr_d;
    word_t        pc4_q, pc4_d;
    logic         valid_q, valid_d;
    logic         ren_q, ren_d;
    fetch_act_t   act_c;
    word_t        pc_plus4_c;

    assign pc_plus4_c = pc_q + WORD_W'(4);

    // Select this cycle's action by priority.
    always_comb begin
        act_c = ACT_BUBBLE;
        if (mem_stall)                     act_c = ACT_STALL;
        else if (flush || redirect_valid)  act_c = ACT_REDIRECT;
        else if (freeze)                   act_c = ACT_FREEZE;
        else if (state_q == RUN && ihit)   act_c = ACT_FETCH;
        else                               act_c = ACT_BUBBLE;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        unique case (act_c)
            ACT_STALL: ;
            ACT_REDIRECT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = RUN;
                end
                if (flush) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            ACT_FREEZE: ;
            ACT_FETCH: begin
                instr_d = imemload;
                pc4_d   = pc_plus4_c;
                valid_d = 1'b1;
                pc_d    = pc_plus4_c;
                if (opcode_of(imemload) == HALT) state_d = HALTED;
            end
            ACT_BUBBLE: begin
                instr_d = '0;
                valid_d = 1'b0;
            end
            default: ;
        endcase
        ren_d = (state_d == RUN);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            ren_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            ren_q   <= ren_d;
        end
    end

    assign imemREN    = ren_q;
    assign imemaddr   = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;

`ifdef FETCH_PERF_EN
    // A miss is a bubble while running; halted bubbles are intentional.
    logic freeze_ev_c, flush_ev_c, miss_ev_c;
    assign freeze_ev_c = (act_c == ACT_FREEZE);
    assign flush_ev_c  = (act_c == ACT_REDIRECT) && flush;
    assign miss_ev_c   = (act_c == ACT_BUBBLE) && (state_q == RUN);

    fetch_perf_counters u_perf (
        .CLK        (CLK),
        .nRST       (nRST),
        .freeze_ev  (freeze_ev_c),
        .flush_ev   (flush_ev_c),
        .miss_ev    (miss_ev_c),
        .freeze_cnt (freeze_cnt),
        .flush_cnt  (flush_cnt),
        .miss_cnt   (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (FETCH_PERF_EN adds counter checks).
module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    fetch_stage_if fif ();

    int n_cmp;
    int n_err;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (fif.ihit),
        .imemload       (fif.imemload),
        .freeze         (fif.freeze),
        .flush          (fif.flush),
        .redirect_valid (fif.redirect_valid),
        .redirect_pc    (fif.redirect_pc),
        .mem_stall      (fif.mem_stall),
        .imemREN        (fif.imemREN),
        .imemaddr       (fif.imemaddr),
        .ifid_instr     (fif.ifid_instr),
        .ifid_pc4       (fif.ifid_pc4),
        .ifid_valid     (fif.ifid_valid)
`ifdef FETCH_PERF_EN
        ,
        .freeze_cnt     (fif.freeze_cnt),
        .flush_cnt      (fif.flush_cnt),
        .miss_cnt       (fif.miss_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        logic  nrst;
        logic  ihit;
        word_t load;
        logic  frz;
        logic  fl;
        logic  rv;
        word_t rpc;
        logic  ms;
        logic  e_ren;
        word_t e_addr;
        word_t e_instr;
        word_t e_pc4;
        logic  e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic nrst_i, input logic ih, input word_t ld,
                       input logic fz, input logic fl, input logic rv, input word_t rpc,
                       input logic ms, input logic ren, input word_t addr, input word_t ins,
                       input word_t p4, input logic vld);
        vec_t v;
        v.name = nm; v.nrst = nrst_i; v.ihit = ih; v.load = ld; v.frz = fz; v.fl = fl;
        v.rv = rv; v.rpc = rpc; v.ms = ms; v.e_ren = ren; v.e_addr = addr;
        v.e_instr = ins; v.e_pc4 = p4; v.e_valid = vld;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic nrst_i, input logic ih, input word_t ld, input logic fz,
                         input logic fl, input logic rv, input word_t rpc, input logic ms);
        nRST = nrst_i; fif.ihit = ih; fif.imemload = ld; fif.freeze = fz;
        fif.flush = fl; fif.redirect_valid = rv; fif.redirect_pc = rpc; fif.mem_stall = ms;
    endtask

    task automatic check_state(input string nm, input logic ren, input word_t addr,
                               input word_t ins, input word_t p4, input logic vld);
        chk({nm, ".ren"},   word_t'(fif.imemREN),    word_t'(ren));
        chk({nm, ".addr"},  fif.imemaddr,            addr);
        chk({nm, ".instr"}, fif.ifid_instr,          ins);
        chk({nm, ".pc4"},   fif.ifid_pc4,            p4);
        chk({nm, ".valid"}, word_t'(fif.ifid_valid), word_t'(vld));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        @(negedge CLK);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        //  name          nrst ih load          fz fl rv rpc           ms  ren addr          instr         pc4           v
        add("reset",      0, 0, 32'h0,         0, 0, 0, 32'h0,         0,  1, 32'h0,        32'h0,        32'h0,        0);
        add("first_hit",  1, 1, 32'h2001_0005, 0, 0, 0, 32'h0,         0,  1, 32'h4,        32'h2001_0005,32'h4,        1);
        add("hit2",       1, 1, 32'h0000_0011, 0, 0, 0, 32'h0,         0,  1, 32'h8,        32'h11,       32'h8,        1);
        add("freeze1",    1, 1, 32'h0000_0022, 1, 0, 0, 32'h0,         0,  1, 32'h8,        32'h11,       32'h8,        1);
        add("freeze2",    1, 1, 32'h0000_0022, 1, 0, 0, 32'h0,         0,  1, 32'h8,        32'h11,       32'h8,        1);
        add("frz_flush",  1, 1, 32'h0000_0022, 1, 1, 0, 32'h0,         0,  1, 32'h8,        32'h0,        32'h0,        0);
        add("nohit",      1, 0, 32'h0000_0099, 0, 0, 0, 32'h0,         0,  1, 32'h8,        32'h0,        32'h0,        0);
        add("hit3",       1, 1, 32'h0000_0033, 0, 0, 0, 32'h0,         0,  1, 32'hC,        32'h33,       32'hC,        1);
        add("redir_fl",   1, 1, 32'h0000_00AA, 0, 1, 1, 32'h100,       0,  1, 32'h100,      32'h0,        32'h0,        0);
        add("hit4",       1, 1, 32'h0000_0044, 0, 0, 0, 32'h0,         0,  1, 32'h104,      32'h44,       32'h104,      1);
        add("redir_only", 1, 1, 32'h0000_0055, 0, 0, 1, 32'h200,       0,  1, 32'h200,      32'h44,       32'h104,      1);
        add("mem_stall",  1, 1, 32'h0000_0066, 1, 1, 1, 32'h300,       1,  1, 32'h200,      32'h44,       32'h104,      1);
        add("halt",       1, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         0,  0, 32'h204,      32'hFFFF_FFFF,32'h204,      1);
        add("halted",     1, 1, 32'h0000_0077, 0, 0, 0, 32'h0,         0,  0, 32'h204,      32'h0,        32'h204,      0);
        add("resume",     1, 0, 32'h0,         0, 0, 1, 32'h40,        0,  1, 32'h40,       32'h0,        32'h204,      0);
        add("hit_40",     1, 1, 32'h0000_0088, 0, 0, 0, 32'h0,         0,  1, 32'h44,       32'h88,       32'h44,       1);
        add("rst_stall",  0, 1, 32'h0000_00BB, 0, 0, 0, 32'h0,         1,  1, 32'h0,        32'h0,        32'h0,        0);
        add("to_top",     1, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC, 0,  1, 32'hFFFF_FFFC,32'h0,        32'h0,        0);
        add("wrap",       1, 1, 32'h0000_00CC, 0, 0, 0, 32'h0,         0,  1, 32'h0,        32'hCC,       32'h0,        1);

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i].nrst, vecs[i].ihit, vecs[i].load, vecs[i].frz, vecs[i].fl,
                  vecs[i].rv, vecs[i].rpc, vecs[i].ms);
            step();
            check_state(vecs[i].name, vecs[i].e_ren, vecs[i].e_addr, vecs[i].e_instr,
                        vecs[i].e_pc4, vecs[i].e_valid);
        end

        // Multi-cycle stall: a pending hit must be accepted only once mem_stall drops.
        @(negedge CLK);
        drive(1'b1, 1'b1, 32'h0000_00DD, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 3; k++) step();
        check_state("long_stall", 1'b1, 32'h0, 32'hCC, 32'h0, 1'b1);
        @(negedge CLK);
        fif.mem_stall = 1'b0;
        step();
        check_state("stall_rel", 1'b1, 32'h4, 32'hDD, 32'h4, 1'b1);

        // Redirect into HALTED together with flush squashes IF/ID.
        @(negedge CLK);
        drive(1'b1, 1'b1, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        check_state("halt2", 1'b0, 32'h8, 32'hFC00_0000, 32'h8, 1'b1);
        @(negedge CLK);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
        step();
        check_state("halt_flush", 1'b1, 32'h80, 32'h0, 32'h0, 1'b0);

`ifdef FETCH_PERF_EN
        @(negedge CLK);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        chk("cnt_rst_miss", fif.miss_cnt, 32'd0);
        @(negedge CLK);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) step();
        @(negedge CLK);
        fif.freeze = 1'b1;
        for (int k = 0; k < 2; k++) step();
        chk("miss_cnt",   fif.miss_cnt,   32'd3);
        chk("freeze_cnt", fif.freeze_cnt, 32'd2);
        chk("flush_cnt",  fif.flush_cnt,  32'd0);
        @(negedge CLK);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step();
        @(negedge CLK);
        fif.flush = 1'b0;
        fif.mem_stall = 1'b1;
        step();
        chk("flush_cnt2",  fif.flush_cnt,  32'd1);
        chk("freeze_cnt2", fif.freeze_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
